// File: rtl/jogo_memoria_param_if.sv
// jogo_memoria_param_if: signal bundle between the game controller and its
// surroundings (debounced buttons, sequence loader, LEDs, debug decoders).
// Signals are named from the controller's point of view:
//   i_jogar          start/restart request, level-sampled
//   i_modo           0 = progressive rounds, 1 = single full-length round
//   i_botoes         debounced player buttons
//   i_carga_valida   sequence memory write strobe
//   i_carga_endereco sequence memory write address
//   i_carga_dado     sequence memory write data (one-hot code)
//   o_leds           displayed step, or echo of the buttons while playing
//   o_ganhou         full sequence completed
//   o_perdeu         wrong move or timeout
//   o_pronto         any end state
//   o_db_rodada      current round index (round 1 = 0)
//   o_db_contagem    current step index within the round
//   o_db_estado      FSM state code
//   o_db_timeout     timeout end state
// Modports: master drives the inputs (board/testbench), slave is the controller.
interface jogo_memoria_param_if #(
   parameter int N_BOTOES     = 4,
   parameter int PROFUNDIDADE = 16
);
   localparam int AW = $clog2(PROFUNDIDADE);

   logic                i_jogar;
   logic                i_modo;
   logic [N_BOTOES-1:0] i_botoes;
   logic                i_carga_valida;
   logic [AW-1:0]       i_carga_endereco;
   logic [N_BOTOES-1:0] i_carga_dado;
   logic [N_BOTOES-1:0] o_leds;
   logic                o_ganhou;
   logic                o_perdeu;
   logic                o_pronto;
   logic [AW-1:0]       o_db_rodada;
   logic [AW-1:0]       o_db_contagem;
   logic [3:0]          o_db_estado;
   logic                o_db_timeout;

   modport master (
      output i_jogar, i_modo, i_botoes, i_carga_valida, i_carga_endereco, i_carga_dado,
      input  o_leds, o_ganhou, o_perdeu, o_pronto, o_db_rodada, o_db_contagem,
             o_db_estado, o_db_timeout
   );

   modport slave (
      input  i_jogar, i_modo, i_botoes, i_carga_valida, i_carga_endereco, i_carga_dado,
      output o_leds, o_ganhou, o_perdeu, o_pronto, o_db_rodada, o_db_contagem,
             o_db_estado, o_db_timeout
   );
endinterface

// File: rtl/jogo_memoria_param.sv
// jogo_memoria_param: parametrised sequence-memory game controller.
// Plays the stored sequence of one-hot codes on the LEDs (one more step per
// round, or the full sequence at once in single-round mode), then checks the
// player's repetition move by move, with a per-move timeout.
// Ports:
//   clk  system clock, all logic on the rising edge
//   rst  asynchronous active-high reset, clears everything except the sequence RAM
//   bus  jogo_memoria_param_if.slave: start/mode, buttons, sequence load port,
//        LEDs, verdict flags and debug outputs
module jogo_memoria_param #(
   parameter int N_BOTOES       = 4,
   parameter int PROFUNDIDADE   = 16,
   parameter int T_LED          = 25_000_000,
   parameter int T_APAGADO      = 12_500_000,
   parameter int TIMEOUT_CICLOS = 150_000_000
) (
   input logic                 clk,
   input logic                 rst,
   jogo_memoria_param_if.slave bus
);
   localparam int AW     = $clog2(PROFUNDIDADE);
   localparam int T_MAX1 = (T_LED > T_APAGADO) ? T_LED : T_APAGADO;
   localparam int T_MAX  = (T_MAX1 > TIMEOUT_CICLOS) ? T_MAX1 : TIMEOUT_CICLOS;
   localparam int TW     = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   localparam logic [AW-1:0]       ULTIMA = AW'(PROFUNDIDADE - 1);
   localparam logic [N_BOTOES-1:0] UM     = N_BOTOES'(1);

   typedef enum logic [3:0] {
      INICIAL     = 4'h0,
      PREPARA     = 4'h1,
      MOSTRA      = 4'h2,
      APAGADO     = 4'h3,
      ESPERA      = 4'h4,
      COMPARA     = 4'h5,
      SOLTA       = 4'h6,
      PROX_RODADA = 4'h7,
      FIM_ACERTO  = 4'hA,
      FIM_ERRO    = 4'hE,
      FIM_TIMEOUT = 4'hF
   } estado_t;

   estado_t             r_estado, w_prox_estado;
   logic                r_modo, w_modo;
   logic [AW-1:0]       r_rodada, w_rodada;
   logic [AW-1:0]       r_contagem, w_contagem;
   logic [TW-1:0]       r_timer, w_timer;
   logic [N_BOTOES-1:0] r_botoes_q;
   logic [N_BOTOES-1:0] r_jogada, w_jogada;
   logic [N_BOTOES-1:0] r_mem [PROFUNDIDADE];

   logic w_ocioso;   // INICIAL or an end state: loading and (re)start allowed
   logic w_solto;
   logic w_borda;
   logic w_acerto;

   assign w_ocioso = (r_estado == INICIAL) || (r_estado == FIM_ACERTO) ||
                     (r_estado == FIM_ERRO) || (r_estado == FIM_TIMEOUT);
   assign w_solto  = (bus.i_botoes == '0);
   // A move is the transition from no button to any button.
   assign w_borda  = (r_botoes_q == '0) && !w_solto;
   // Non-one-hot presses never match, even if the RAM holds a bad code.
   assign w_acerto = (r_jogada == r_mem[r_contagem]) && (r_jogada != '0) &&
                     ((r_jogada & (r_jogada - UM)) == '0);

   // NOTE: the sequence RAM has no reset so it maps onto plain registers/RAM
   // and keeps its contents across a mid-game reset.
   always_ff @(posedge clk) begin
      if (bus.i_carga_valida && w_ocioso) begin
         r_mem[bus.i_carga_endereco] <= bus.i_carga_dado;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values from before the clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_estado   <= INICIAL;
         r_modo     <= 1'b0;
         r_rodada   <= '0;
         r_contagem <= '0;
         r_timer    <= '0;
         r_botoes_q <= '0;
         r_jogada   <= '0;
      end else begin
         r_estado   <= w_prox_estado;
         r_modo     <= w_modo;
         r_rodada   <= w_rodada;
         r_contagem <= w_contagem;
         r_timer    <= w_timer;
         r_botoes_q <= bus.i_botoes;
         r_jogada   <= w_jogada;
      end
   end

   // NOTE: every signal written here gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      w_prox_estado = r_estado;
      w_modo        = r_modo;
      w_rodada      = r_rodada;
      w_contagem    = r_contagem;
      w_timer       = r_timer + 1'b1;
      w_jogada      = r_jogada;

      case (r_estado)
         INICIAL, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
            w_timer = '0;
            if (bus.i_jogar) begin
               w_prox_estado = PREPARA;
               w_modo        = bus.i_modo;
            end
         end
         PREPARA: begin
            w_contagem    = '0;
            w_rodada      = r_modo ? ULTIMA : '0;
            w_timer       = '0;
            w_prox_estado = MOSTRA;
         end
         MOSTRA: begin
            if (r_timer == TW'(T_LED - 1)) begin
               w_timer       = '0;
               w_prox_estado = APAGADO;
            end
         end
         APAGADO: begin
            if (r_timer == TW'(T_APAGADO - 1)) begin
               w_timer = '0;
               if (r_contagem == r_rodada) begin
                  w_contagem    = '0;
                  w_prox_estado = ESPERA;
               end else begin
                  w_contagem    = r_contagem + 1'b1;
                  w_prox_estado = MOSTRA;
               end
            end
         end
         ESPERA: begin
            // Checked before the timeout so a move on the last cycle wins.
            if (w_borda) begin
               w_jogada      = bus.i_botoes;
               w_prox_estado = COMPARA;
            end else if (r_timer == TW'(TIMEOUT_CICLOS - 1)) begin
               w_prox_estado = FIM_TIMEOUT;
            end
         end
         COMPARA: begin
            w_timer = '0;
            if (!w_acerto) begin
               w_prox_estado = FIM_ERRO;
            end else if (r_contagem != r_rodada) begin
               w_contagem    = r_contagem + 1'b1;
               w_prox_estado = SOLTA;
            end else if (r_rodada == ULTIMA) begin
               w_prox_estado = FIM_ACERTO;
            end else begin
               w_prox_estado = PROX_RODADA;
            end
         end
         SOLTA: begin
            if (w_solto) begin
               w_timer       = '0;
               w_prox_estado = ESPERA;
            end else if (r_timer == TW'(TIMEOUT_CICLOS - 1)) begin
               w_prox_estado = FIM_TIMEOUT;
            end
         end
         PROX_RODADA: begin
            if (w_solto) begin
               w_rodada      = r_rodada + 1'b1;
               w_contagem    = '0;
               w_timer       = '0;
               w_prox_estado = MOSTRA;
            end
         end
         default: w_prox_estado = INICIAL;
      endcase
   end

   always_comb begin
      bus.o_leds = '0;
      case (r_estado)
         MOSTRA:                              bus.o_leds = r_mem[r_contagem];
         ESPERA, COMPARA, SOLTA, PROX_RODADA: bus.o_leds = r_botoes_q;
         default:                             bus.o_leds = '0;
      endcase
   end

   assign bus.o_ganhou      = (r_estado == FIM_ACERTO);
   assign bus.o_perdeu      = (r_estado == FIM_ERRO) || (r_estado == FIM_TIMEOUT);
   assign bus.o_pronto      = (r_estado == FIM_ACERTO) || (r_estado == FIM_ERRO) ||
                              (r_estado == FIM_TIMEOUT);
   assign bus.o_db_timeout  = (r_estado == FIM_TIMEOUT);
   assign bus.o_db_rodada   = r_rodada;
   assign bus.o_db_contagem = r_contagem;
   assign bus.o_db_estado   = r_estado;
endmodule

// File: doc/jogo_memoria_param.md
# jogo_memoria_param

Parametrised sequence-memory game controller: plays a stored sequence of one-hot button codes on the LEDs, then checks the player's repetition, round by round. Replaces the fixed 4-button, 16-step game core with configurable button count, depth, timing and a selectable single-round mode. It adds a sequence load port and an explicit LED display phase. It sits between the debounced button inputs and the board LEDs/7-segment debug decoders.

## Interface

- N_BOTOES, 4: number of buttons/LEDs (≥2); codes are one-hot N_BOTOES bits
- PROFUNDIDADE, 16: sequence length/max rounds (power of 2, ≥2); AW = $clog2(PROFUNDIDADE)
- T_LED, 25_000_000: cycles each LED is lit in display phase
- T_APAGADO, 12_500_000: dark cycles between displayed steps
- TIMEOUT_CICLOS, 150_000_000: cycles allowed per player move
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- jogar  in  1  start/restart request, level-sampled
- modo  in  1  latched on start: 0 = progressive rounds 1..PROFUNDIDADE, 1 = single round of full length
- botoes  in  N_BOTOES  player buttons, already debounced
- carga_valida  in  1  write strobe for sequence memory
- carga_endereco  in  AW  write address
- carga_dado  in  N_BOTOES  write data (one-hot code)
- leds  out  N_BOTOES  displayed step during display phase; echoes botoes during play phase
- ganhou  out  1  held high after full sequence completed
- perdeu  out  1  held high after wrong move or timeout
- pronto  out  1  high in any end state
- db_rodada  out  AW  current round index (round 1 = 0)
- db_contagem  out  AW  current step index within round
- db_estado  out  4  FSM state code
- db_timeout  out  1  high in the timeout end state

## Operation

- Sequence RAM: PROFUNDIDADE × N_BOTOES registers, synchronous write when carga_valida=1 in INICIAL or any end state; ignored otherwise. Not cleared by reset.
- Move capture: a move is registered on the cycle botoes changes from all-zero to non-zero; the next move is accepted only after botoes returns to all-zero. A non-one-hot value counts as a wrong move.
- FSM states and codes: INICIAL 0, PREPARA 1, MOSTRA 2, APAGADO 3, ESPERA 4, COMPARA 5, SOLTA 6, PROX_RODADA 7, FIM_ACERTO A, FIM_ERRO E, FIM_TIMEOUT F.
- INICIAL/end states: jogar=1 -> PREPARA; modo latched.
- PREPARA (1 cycle): contagem=0; rodada=0 if modo=0, PROFUNDIDADE-1 if modo=1; timers cleared -> MOSTRA.
- MOSTRA: leds=mem[contagem] for T_LED cycles -> APAGADO. APAGADO: leds=0 for T_APAGADO cycles; if contagem==rodada then contagem=0 -> ESPERA, else contagem+1 -> MOSTRA.
- ESPERA: timeout counter runs; captured move -> COMPARA; counter reaching TIMEOUT_CICLOS-1 -> FIM_TIMEOUT.
- COMPARA (1 cycle): mismatch -> FIM_ERRO; match and contagem<rodada -> contagem+1, SOLTA; match and contagem==rodada: if rodada==PROFUNDIDADE-1 -> FIM_ACERTO, else -> PROX_RODADA.
- SOLTA: waits for botoes=0, timeout counter cleared on entry and running -> ESPERA (or FIM_TIMEOUT).
- PROX_RODADA: waits for botoes=0, then rodada+1, contagem=0 -> MOSTRA.
- End states: ganhou (FIM_ACERTO), perdeu (FIM_ERRO, FIM_TIMEOUT), db_timeout (FIM_TIMEOUT) and pronto held until jogar.

## Timing

- Reset values: leds=0, ganhou=0, perdeu=0, pronto=0, db_rodada=0, db_contagem=0, db_estado=0, db_timeout=0; FSM in INICIAL.
- All outputs registered or decoded from registered state; no combinational path botoes->ganhou/perdeu.
- Move-to-verdict latency: edge detected in cycle n, COMPARA in n+1, end state/outputs visible at n+2.
- Timeout fires exactly TIMEOUT_CICLOS cycles after entry into ESPERA with no move.
- jogar high while in an end state restarts even if held across cycles; jogar ignored in all other states.
- Move and timeout in the same cycle: move wins.
- Reset mid-game: immediate return to INICIAL, all outputs 0, memory contents kept.
- Counters sized AW bits; rodada never wraps (end condition checked before increment).

## Test plan

- Bench parameters: N_BOTOES=4, PROFUNDIDADE=4, T_LED=4, T_APAGADO=2, TIMEOUT_CICLOS=50.
- Load 0001,0010,0100,1000; modo=0; jogar; echo each displayed sequence, rounds 1..4 -> display of round k lasts k×6 cycles, ganhou=1, pronto=1, db_estado=A.
- Same load; round 3, second move 0100 instead of 0010 -> perdeu=1, db_estado=E, db_rodada=2, db_contagem=1, two cycles after the press.
- No move after round 1 display -> FIM_TIMEOUT exactly 50 cycles after entering ESPERA, db_timeout=1, perdeu=1.
- modo=1: display shows all 4 steps once; correct 4 moves -> ganhou; press 0011 at step 0 -> perdeu.
- Reset asserted during MOSTRA of round 2 -> all outputs 0 asynchronously; jogar replays the same sequence; carga_valida during ESPERA does not alter memory.
